// File: rtl/tri_state.sv
// Tristate output driver with a clocked read-back monitor of the resolved bus.
// The data path is purely combinational; only the monitor is affected by Clock/Reset.
module tri_state #(
    parameter int WIDTH = 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] DataIn,
    input  logic             OutputEnable,
    inout  wire  [WIDTH-1:0] DataOut,
    output logic [WIDTH-1:0] BusSample,
    output logic             Driving,
    output logic             Contention
);

    // One enable gates every bit; reset deliberately does not release the bus.
    assign DataOut = OutputEnable ? DataIn : {WIDTH{1'bz}};

    // Case-inequality so an X/Z on the resolved bus counts as a disagreement.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            BusSample  <= '0;
            Driving    <= 1'b0;
            Contention <= 1'b0;
        end else begin
            BusSample  <= DataOut;
            Driving    <= OutputEnable;
            Contention <= OutputEnable && (DataOut !== DataIn);
        end
    end

endmodule

// File: tb/tb_tri_state.sv
// Directed checks of tri_state: combinational drive/release, monitor lag,
// contention against a bench driver, async reset, and an 8-bit instance.
module tb_tri_state;

    logic       Clock;
    logic       Reset;
    logic       in1;
    logic       en1;
    logic [7:0] in8;
    logic       en8;
    logic       drv_en;
    logic       drv_val;

    wire        bus1;
    wire  [7:0] bus8;
    logic       sample1;
    logic       driving1;
    logic       contention1;
    logic [7:0] sample8;
    logic       driving8;
    logic       contention8;

    int n_checks = 0;
    int n_fail   = 0;

    // Second driver on the 1-bit bus, used to provoke contention.
    assign bus1 = drv_en ? drv_val : 1'bz;

    tri_state #(.WIDTH(1)) u_dut1 (
        .Clock       (Clock),
        .Reset       (Reset),
        .DataIn      (in1),
        .OutputEnable(en1),
        .DataOut     (bus1),
        .BusSample   (sample1),
        .Driving     (driving1),
        .Contention  (contention1)
    );

    tri_state #(.WIDTH(8)) u_dut8 (
        .Clock       (Clock),
        .Reset       (Reset),
        .DataIn      (in8),
        .OutputEnable(en8),
        .DataOut     (bus8),
        .BusSample   (sample8),
        .Driving     (driving8),
        .Contention  (contention8)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Reset   = 1'b1;
        in1     = 1'b0;
        en1     = 1'b0;
        in8     = 8'h00;
        en8     = 1'b0;
        drv_en  = 1'b0;
        drv_val = 1'b0;

        // Reset state
        #12;
        check("rst_driving1",    {7'd0, driving1},    8'h00);
        check("rst_contention1", {7'd0, contention1}, 8'h00);
        check("rst_sample1",     {7'd0, sample1},     8'h00);
        check("rst_driving8",    {7'd0, driving8},    8'h00);
        check("rst_sample8",     sample8,             8'h00);
        Reset = 1'b0;

        // Released with In=0: bus floats, monitor reports not driving
        #1;
        check("idle_bus_z", {7'd0, (bus1 === 1'bz)}, 8'h01);
        tick();
        check("idle_driving",    {7'd0, driving1},    8'h00);
        check("idle_contention", {7'd0, contention1}, 8'h00);

        // Toggle with enable: bus follows immediately, monitor one edge later
        en1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in1 = i[0];
            #1;
            check($sformatf("tog%0d_bus", i), {7'd0, bus1}, {7'd0, i[0]});
            tick();
            check($sformatf("tog%0d_sample", i),     {7'd0, sample1},     {7'd0, i[0]});
            check($sformatf("tog%0d_contention", i), {7'd0, contention1}, 8'h00);
            check($sformatf("tog%0d_driving", i),    {7'd0, driving1},    8'h01);
        end

        // Disable with In=1: bus goes to Z with no clock edge
        in1 = 1'b1;
        en1 = 1'b0;
        #1;
        check("dis_bus_z", {7'd0, (bus1 === 1'bz)}, 8'h01);
        in1 = 1'b0;
        #1;
        check("dis_in0_bus_z", {7'd0, (bus1 === 1'bz)}, 8'h01);
        tick();
        check("dis_driving",    {7'd0, driving1},    8'h00);
        check("dis_contention", {7'd0, contention1}, 8'h00);

        // Contention: DUT drives 0, bench drives a strong 1
        en1     = 1'b1;
        in1     = 1'b0;
        drv_val = 1'b1;
        drv_en  = 1'b1;
        #1;
        check("cont_bus_differs", {7'd0, (bus1 !== in1)}, 8'h01);
        tick();
        check("cont_flag",    {7'd0, contention1}, 8'h01);
        check("cont_driving", {7'd0, driving1},    8'h01);
        drv_en = 1'b0;
        tick();
        check("cont_cleared", {7'd0, contention1}, 8'h00);

        // Async reset between edges while driving
        in1 = 1'b1;
        tick();
        check("pre_rst_driving", {7'd0, driving1}, 8'h01);
        check("pre_rst_sample",  {7'd0, sample1},  8'h01);
        #3;
        Reset = 1'b1;
        #1;
        check("arst_driving",    {7'd0, driving1},    8'h00);
        check("arst_sample",     {7'd0, sample1},     8'h00);
        check("arst_contention", {7'd0, contention1}, 8'h00);
        check("arst_bus_held",   {7'd0, bus1},        8'h01);
        in1 = 1'b0;
        #1;
        check("arst_bus_follows", {7'd0, bus1}, 8'h00);
        Reset = 1'b0;
        tick();
        check("post_rst_driving", {7'd0, driving1}, 8'h01);
        check("post_rst_sample",  {7'd0, sample1},  8'h00);

        // 8-bit instance
        in8 = 8'hA5;
        en8 = 1'b1;
        #1;
        check("w8_bus", bus8, 8'hA5);
        tick();
        check("w8_sample",     sample8,             8'hA5);
        check("w8_driving",    {7'd0, driving8},    8'h01);
        check("w8_contention", {7'd0, contention8}, 8'h00);
        en8 = 1'b0;
        #1;
        check("w8_bus_z", {7'd0, (bus8 === 8'hzz)}, 8'h01);
        tick();
        check("w8_dis_driving", {7'd0, driving8}, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
